// File: rtl/sc_lut_arb_pkg.sv
// Shared sine/cosine LUT sizing and helpers.
// Used by the LUT arbiter and its round-robin core.
package sc_lut_arb_pkg;

  localparam int SC_ASZ     = 10;
  localparam int SC_DSZ     = 14;
  localparam int SC_LUT_LAT = 2;
  localparam int SC_MAXREQ  = 8;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin priority pick: first request at or after ptr wins.
// Purely combinational.
module rr_arb
  import sc_lut_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Scan lowest priority first so the highest-priority hit is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = PW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_lut_arb.sv
// Shares one sin/cos LUT among NREQ requesters, one lookup per clock,
// and steers each LUT result back to its issuer after LAT clocks.
module sc_lut_arb
  import sc_lut_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ASZ  = SC_ASZ,
  parameter int DSZ  = SC_DSZ,
  parameter int LAT  = SC_LUT_LAT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*ASZ-1:0] addr,
  output logic [NREQ-1:0]     gnt,
  output logic [ASZ-1:0]      lut_a,
  input  logic [DSZ-1:0]      lut_d,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [DSZ-1:0]      rsp_d
);

  localparam int PW = ptr_w(NREQ);

  logic [PW-1:0]            ptr;
  logic [PW-1:0]            idx;
  logic                     any;
  logic [LAT-1:0][NREQ-1:0] tags;

  rr_arb #(.N(NREQ)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  assign lut_a = any ? addr[idx*ASZ +: ASZ] : '0;

  // A zero tag means no lookup was issued in that slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr  <= '0;
      tags <= '0;
    end else begin
      if (any)
        ptr <= (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
      tags[0] <= gnt;
      for (int i = 1; i < LAT; i++)
        tags[i] <= tags[i-1];
    end
  end

  assign rsp_valid = tags[LAT-1];
  assign rsp_d     = lut_d;

endmodule

// File: tb/tb_sc_lut_arb.sv
// Scoreboard bench for sc_lut_arb with a 2-cycle LUT model (d = a<<4).
// Stimulus queues expected responses; a monitor checks them on arrival.
module tb_sc_lut_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [39:0] addr = '0;
  logic [3:0]  gnt;
  logic [9:0]  lut_a;
  logic [13:0] lut_d;
  logic [3:0]  rsp_valid;
  logic [13:0] rsp_d;

  logic [9:0]  ar;
  logic [9:0]  a [4];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          mptr = 0;

  typedef struct {
    logic [3:0]  id;
    logic [13:0] d;
    int          due;
  } exp_t;

  exp_t q[$];

  sc_lut_arb #(.NREQ(4), .ASZ(10), .DSZ(14), .LAT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .addr      (addr),
    .gnt       (gnt),
    .lut_a     (lut_a),
    .lut_d     (lut_d),
    .rsp_valid (rsp_valid),
    .rsp_d     (rsp_d)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    ar    <= lut_a;
    lut_d <= {ar, 4'b0000};
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, ex);
    end
  endtask

  function automatic logic [3:0] model_gnt(input logic [3:0] rq);
    logic [3:0] g;
    g = '0;
    for (int k = 3; k >= 0; k--)
      if (rq[(mptr + k) % 4]) begin
        g = '0;
        g[(mptr + k) % 4] = 1'b1;
      end
    return g;
  endfunction

  // One clock: drive req/addr, check grant and address, queue the response.
  task automatic step(input logic [3:0] rq, input logic [3:0] ex,
                      input string nm);
    exp_t e;
    logic [9:0] ea;
    int w;
    @(posedge clk);
    #1;
    req  = rq;
    addr = {a[3], a[2], a[1], a[0]};
    @(negedge clk);
    w  = -1;
    ea = '0;
    for (int i = 0; i < 4; i++)
      if (ex[i]) w = i;
    if (w >= 0) ea = a[w];
    chk({nm, "_gnt"}, 32'(gnt), 32'(ex));
    chk({nm, "_lut_a"}, 32'(lut_a), 32'(ea));
    if (w >= 0) begin
      e.id  = ex;
      e.d   = {ea, 4'b0000};
      e.due = cyc + 2;
      q.push_back(e);
      mptr = (w + 1) % 4;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      if (rsp_valid != '0) begin
        if (q.size() == 0) begin
          chk("rsp_spurious", 32'(rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_id", 32'(rsp_valid), 32'(e.id));
          chk("rsp_d", 32'(rsp_d), 32'(e.d));
          chk("rsp_latency", 32'(cyc), 32'(e.due));
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        chk("rsp_missing", 32'(rsp_valid), 32'(q[0].id));
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int c3, c0;
    logic [3:0] rq;
    for (int i = 0; i < 4; i++) a[i] = '0;

    // In reset: grant follows req, nothing is tracked.
    a[1] = 10'd77;
    @(posedge clk);
    #1;
    req  = 4'b0010;
    addr = {a[3], a[2], a[1], a[0]};
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h2);
    chk("rst_lut_a", 32'(lut_a), 32'd77);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = '0;
    mptr  = 0;

    // All four rise together after reset.
    a[0] = 10'd10; a[1] = 10'd20; a[2] = 10'd30; a[3] = 10'd40;
    step(4'b1111, 4'b0001, "all");
    step(4'b1111, 4'b0010, "all");
    step(4'b1111, 4'b0100, "all");
    step(4'b1111, 4'b1000, "all");
    step(4'b1111, 4'b0001, "all");
    step(4'b1111, 4'b0010, "all");
    step(4'b1111, 4'b0100, "all");
    step(4'b1111, 4'b1000, "all");

    // Single requester, back-to-back grants.
    a[0] = 10'd0;
    for (int i = 0; i < 4; i++) step(4'b0001, 4'b0001, "single");
    a[0] = 10'd256;
    step(4'b0001, 4'b0001, "single");
    step(4'b0001, 4'b0001, "single");
    step(4'b0000, 4'b0000, "idle");
    step(4'b0000, 4'b0000, "idle");

    // Isolated pulses with idle gaps.
    a[2] = 10'd300; a[1] = 10'd5;
    step(4'b0100, 4'b0100, "gap");
    step(4'b0000, 4'b0000, "gap");
    step(4'b0000, 4'b0000, "gap");
    step(4'b0010, 4'b0010, "gap");
    for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000, "gap");

    // Wrap: put ptr at 3, then 1001 alternates 1000/0001.
    a[3] = 10'd1023; a[0] = 10'd1;
    step(4'b0100, 4'b0100, "wrap_pre");
    c3 = 0;
    c0 = 0;
    for (int i = 0; i < 100; i++) begin
      step(4'b1001, (i % 2 == 0) ? 4'b1000 : 4'b0001, "wrap");
      if (gnt == 4'b1000) c3++;
      if (gnt == 4'b0001) c0++;
    end
    chk("fair_cnt3", 32'(c3), 32'd50);
    chk("fair_cnt0", 32'(c0), 32'd50);
    step(4'b0000, 4'b0000, "idle");
    step(4'b0000, 4'b0000, "idle");

    // Reset one cycle after a grant discards the tag and clears ptr.
    a[0] = 10'd99;
    step(4'b0001, 4'b0001, "midrst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    req   = '0;
    q.delete();
    mptr  = 0;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_after", 32'(rsp_valid), 32'd0);
    a[0] = 10'd11; a[1] = 10'd22; a[2] = 10'd33; a[3] = 10'd44;
    step(4'b1111, 4'b0001, "postrst");
    step(4'b0000, 4'b0000, "idle");
    step(4'b0000, 4'b0000, "idle");

    // Random requests and addresses against the round-robin model.
    for (int i = 0; i < 2000; i++) begin
      for (int j = 0; j < 4; j++) a[j] = 10'($urandom_range(0, 1023));
      rq = 4'($urandom_range(0, 15));
      step(rq, model_gnt(rq), "rand");
    end
    for (int i = 0; i < 4; i++) step(4'b0000, 4'b0000, "drain");
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
